// File: rtl/bomberman_pkg.sv
// ---------------------------------------------------------------------------
// bomberman_pkg
// Shared constants and types for the arena arbiter and its helpers:
//   - arena geometry (10x10 cells, index = y*10 + x)
//   - cell codes, player command codes and arbiter FSM states
//   - the initial block layout and player start positions
//   - cellIdx(): converts an (x, y) coordinate into a flat cell index
// ---------------------------------------------------------------------------
package bomberman_pkg;

    localparam int ARENA_W = 10;
    localparam int ARENA_H = 10;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLOCK = 2'b01,
        PLR_A = 2'b10,
        PLR_B = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        CMD_UP    = 3'd0,
        CMD_DOWN  = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_RIGHT = 3'd3,
        CMD_PLANT = 3'd4
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SCAN,
        ST_REPORT
    } state_t;

    localparam logic [6:0] START_A_IDX = 7'd11;
    localparam logic [6:0] START_B_IDX = 7'd88;

    localparam logic [3:0] START_AX = 4'(int'(START_A_IDX) % ARENA_W);
    localparam logic [3:0] START_AY = 4'(int'(START_A_IDX) / ARENA_W);
    localparam logic [3:0] START_BX = 4'(int'(START_B_IDX) % ARENA_W);
    localparam logic [3:0] START_BY = 4'(int'(START_B_IDX) / ARENA_W);

    localparam logic [99:0] INIT_BLOCKS =
        (100'd1 << 13) | (100'd1 << 17) | (100'd1 << 24) | (100'd1 << 32) |
        (100'd1 << 34) | (100'd1 << 38) | (100'd1 << 46) | (100'd1 << 51) |
        (100'd1 << 56) | (100'd1 << 57) | (100'd1 << 62) | (100'd1 << 63) |
        (100'd1 << 76) | (100'd1 << 84);

    // Plane 0 carries the low cell bit (blocks and player B), plane 1 the
    // high bit (both players).
    localparam logic [99:0] INIT_ARENA0 = INIT_BLOCKS | (100'd1 << START_B_IDX);
    localparam logic [99:0] INIT_ARENA1 = (100'd1 << START_A_IDX) | (100'd1 << START_B_IDX);

    function automatic logic [6:0] cellIdx(input logic [3:0] x, input logic [3:0] y,
                                           input int w);
        return 7'(int'(y) * w + int'(x));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a priority override.
//   req_a_i / req_b_i : player requests
//   prio_i            : override request (bomb tick), always wins
//   ptr_b_i           : round-robin pointer, 1 = B preferred on a tie
//   gnt_a_o / gnt_b_o : one-hot player grants (never with gnt_prio_o)
//   gnt_prio_o        : override granted
// Purely combinational; the owner keeps the pointer register.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic prio_i,
    input  logic ptr_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o,
    output logic gnt_prio_o
);

    // A lone requester wins regardless of the pointer; the pointer only
    // breaks a tie between A and B.
    assign gnt_prio_o = prio_i;
    assign gnt_a_o    = !prio_i && req_a_i && (!req_b_i || !ptr_b_i);
    assign gnt_b_o    = !prio_i && req_b_i && (!req_a_i ||  ptr_b_i);

endmodule

// File: rtl/arena_arbiter.sv
// ---------------------------------------------------------------------------
// arena_arbiter
// Sole owner of the arena and bomb maps. Serialises player A, player B and
// bomb-tick updates and publishes the maps as flat bit-planes.
//   clk, rst            : clock, synchronous active-high reset
//   tick                : one-cycle bomb tick strobe
//   a_req/a_cmd/a_ack/a_ok, b_req/b_cmd/b_ack/b_ok : player handshakes
//   arena_0/1, bombs_0/1: map bit-planes, index = y*10 + x
//   playerAx/Ay/Bx/By   : player coordinates
//   hit_a, hit_b        : one-cycle pulse after a scan that hit a player
//   busy                : FSM not idle
// ---------------------------------------------------------------------------
module arena_arbiter
    import bomberman_pkg::*;
#(
    parameter int         GRID_W    = ARENA_W,
    parameter int         GRID_H    = ARENA_H,
    parameter logic [1:0] FUSE_INIT = 2'd3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         a_req,
    input  logic [2:0]   a_cmd,
    output logic         a_ack,
    output logic         a_ok,
    input  logic         b_req,
    input  logic [2:0]   b_cmd,
    output logic         b_ack,
    output logic         b_ok,
    output logic [99:0]  arena_0,
    output logic [99:0]  arena_1,
    output logic [99:0]  bombs_0,
    output logic [99:0]  bombs_1,
    output logic [3:0]   playerAx,
    output logic [3:0]   playerAy,
    output logic [3:0]   playerBx,
    output logic [3:0]   playerBy,
    output logic         hit_a,
    output logic         hit_b,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [99:0]  arena0_q, arena0_d, arena1_q, arena1_d;
    logic [99:0]  bombs0_q, bombs0_d, bombs1_q, bombs1_d;
    logic [3:0]   ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
    logic         tickPend_q, tickPend_d;
    logic         rrPtr_q, rrPtr_d;
    logic         curIsB_q, curIsB_d;
    logic [2:0]   cmd_q, cmd_d;
    logic [6:0]   idx_q, idx_d;
    logic         hitPendA_q, hitPendA_d, hitPendB_q, hitPendB_d;
    logic         aAck_q, aAck_d, aOk_q, aOk_d, bAck_q, bAck_d, bOk_q, bOk_d;
    logic         hitA_q, hitA_d, hitB_q, hitB_d;

    logic         gntA, gntB, gntTick;
    logic [3:0]   curX, curY, tgtX, tgtY, scanX, scanY;
    logic [1:0]   curCode, fuse, fuseDec;
    logic [6:0]   curIdx, tgtIdx;
    logic         inGrid, isMove, applyOk;
    logic [6:0]   crossIdx [5];
    logic         crossOk  [5];

    // A tick arriving in the same cycle as a player request must still win,
    // so the raw strobe joins the registered pending flag.
    rr_arb2 u_arb (
        .req_a_i    (a_req),
        .req_b_i    (b_req),
        .prio_i     (tickPend_q | tick),
        .ptr_b_i    (rrPtr_q),
        .gnt_a_o    (gntA),
        .gnt_b_o    (gntB),
        .gnt_prio_o (gntTick)
    );

    // Next-state logic: arbitration in IDLE, a single map update in APPLY,
    // one cell per cycle in SCAN, and the hit pulses in REPORT.
    always_comb begin
        state_d    = state_q;
        arena0_d   = arena0_q;
        arena1_d   = arena1_q;
        bombs0_d   = bombs0_q;
        bombs1_d   = bombs1_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        bx_d       = bx_q;
        by_d       = by_q;
        tickPend_d = tickPend_q | tick;
        rrPtr_d    = rrPtr_q;
        curIsB_d   = curIsB_q;
        cmd_d      = cmd_q;
        idx_d      = idx_q;
        hitPendA_d = hitPendA_q;
        hitPendB_d = hitPendB_q;
        aAck_d     = 1'b0;
        aOk_d      = 1'b0;
        bAck_d     = 1'b0;
        bOk_d      = 1'b0;
        hitA_d     = 1'b0;
        hitB_d     = 1'b0;
        applyOk    = 1'b0;

        curX    = curIsB_q ? bx_q : ax_q;
        curY    = curIsB_q ? by_q : ay_q;
        curCode = curIsB_q ? PLR_B : PLR_A;
        tgtX    = curX;
        tgtY    = curY;
        inGrid  = 1'b1;
        isMove  = 1'b1;
        case (cmd_q)
            CMD_UP:    if (curY == 4'd0) inGrid = 1'b0; else tgtY = curY - 4'd1;
            CMD_DOWN:  if (int'(curY) == GRID_H - 1) inGrid = 1'b0; else tgtY = curY + 4'd1;
            CMD_LEFT:  if (curX == 4'd0) inGrid = 1'b0; else tgtX = curX - 4'd1;
            CMD_RIGHT: if (int'(curX) == GRID_W - 1) inGrid = 1'b0; else tgtX = curX + 4'd1;
            default:   isMove = 1'b0;
        endcase
        curIdx = cellIdx(curX, curY, GRID_W);
        tgtIdx = cellIdx(tgtX, tgtY, GRID_W);

        // Blast cross around the scanned cell; edge cells drop the
        // neighbours that would wrap onto another row or fall off the grid.
        fuse        = {bombs1_q[idx_q], bombs0_q[idx_q]};
        fuseDec     = fuse - 2'd1;
        scanX       = 4'(int'(idx_q) % GRID_W);
        scanY       = 4'(int'(idx_q) / GRID_W);
        crossIdx[0] = idx_q;
        crossIdx[1] = idx_q - 7'(GRID_W);
        crossIdx[2] = idx_q + 7'(GRID_W);
        crossIdx[3] = idx_q - 7'd1;
        crossIdx[4] = idx_q + 7'd1;
        crossOk[0]  = 1'b1;
        crossOk[1]  = (scanY != 4'd0);
        crossOk[2]  = (int'(scanY) != GRID_H - 1);
        crossOk[3]  = (scanX != 4'd0);
        crossOk[4]  = (int'(scanX) != GRID_W - 1);

        case (state_q)
            ST_IDLE: begin
                if (gntTick) begin
                    state_d    = ST_SCAN;
                    idx_d      = 7'd0;
                    tickPend_d = 1'b0;
                end else if (gntA || gntB) begin
                    state_d  = ST_APPLY;
                    curIsB_d = gntB;
                    cmd_d    = gntB ? b_cmd : a_cmd;
                    rrPtr_d  = gntA;
                end
            end
            ST_APPLY: begin
                if (isMove) begin
                    if (inGrid && {arena1_q[tgtIdx], arena0_q[tgtIdx]} == EMPTY &&
                        {bombs1_q[tgtIdx], bombs0_q[tgtIdx]} == 2'b00) begin
                        applyOk          = 1'b1;
                        arena0_d[curIdx] = 1'b0;
                        arena1_d[curIdx] = 1'b0;
                        arena0_d[tgtIdx] = curCode[0];
                        arena1_d[tgtIdx] = curCode[1];
                        if (curIsB_q) begin
                            bx_d = tgtX;
                            by_d = tgtY;
                        end else begin
                            ax_d = tgtX;
                            ay_d = tgtY;
                        end
                    end
                end else if (cmd_q == CMD_PLANT) begin
                    if ({bombs1_q[curIdx], bombs0_q[curIdx]} == 2'b00) begin
                        applyOk          = 1'b1;
                        bombs0_d[curIdx] = FUSE_INIT[0];
                        bombs1_d[curIdx] = FUSE_INIT[1];
                    end
                end
                aAck_d  = !curIsB_q;
                aOk_d   = !curIsB_q && applyOk;
                bAck_d  = curIsB_q;
                bOk_d   = curIsB_q && applyOk;
                state_d = ST_IDLE;
            end
            ST_SCAN: begin
                if (fuse > 2'd1) begin
                    bombs0_d[idx_q] = fuseDec[0];
                    bombs1_d[idx_q] = fuseDec[1];
                end else if (fuse == 2'd1) begin
                    bombs0_d[idx_q] = 1'b0;
                    bombs1_d[idx_q] = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        if (crossOk[k]) begin
                            if ({arena1_q[crossIdx[k]], arena0_q[crossIdx[k]]} == BLOCK) begin
                                arena0_d[crossIdx[k]] = 1'b0;
                                arena1_d[crossIdx[k]] = 1'b0;
                            end else if ({arena1_q[crossIdx[k]], arena0_q[crossIdx[k]]} == PLR_A) begin
                                hitPendA_d = 1'b1;
                            end else if ({arena1_q[crossIdx[k]], arena0_q[crossIdx[k]]} == PLR_B) begin
                                hitPendB_d = 1'b1;
                            end
                        end
                    end
                end
                if (idx_q == 7'(GRID_W * GRID_H - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            ST_REPORT: begin
                hitA_d     = hitPendA_q;
                hitB_d     = hitPendB_q;
                hitPendA_d = 1'b0;
                hitPendB_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset restores the start layout and drops any
    // operation or pending tick in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            arena0_q   <= INIT_ARENA0;
            arena1_q   <= INIT_ARENA1;
            bombs0_q   <= '0;
            bombs1_q   <= '0;
            ax_q       <= START_AX;
            ay_q       <= START_AY;
            bx_q       <= START_BX;
            by_q       <= START_BY;
            tickPend_q <= 1'b0;
            rrPtr_q    <= 1'b0;
            curIsB_q   <= 1'b0;
            cmd_q      <= 3'd0;
            idx_q      <= 7'd0;
            hitPendA_q <= 1'b0;
            hitPendB_q <= 1'b0;
            aAck_q     <= 1'b0;
            aOk_q      <= 1'b0;
            bAck_q     <= 1'b0;
            bOk_q      <= 1'b0;
            hitA_q     <= 1'b0;
            hitB_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            arena0_q   <= arena0_d;
            arena1_q   <= arena1_d;
            bombs0_q   <= bombs0_d;
            bombs1_q   <= bombs1_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            tickPend_q <= tickPend_d;
            rrPtr_q    <= rrPtr_d;
            curIsB_q   <= curIsB_d;
            cmd_q      <= cmd_d;
            idx_q      <= idx_d;
            hitPendA_q <= hitPendA_d;
            hitPendB_q <= hitPendB_d;
            aAck_q     <= aAck_d;
            aOk_q      <= aOk_d;
            bAck_q     <= bAck_d;
            bOk_q      <= bOk_d;
            hitA_q     <= hitA_d;
            hitB_q     <= hitB_d;
        end
    end

    assign a_ack    = aAck_q;
    assign a_ok     = aOk_q;
    assign b_ack    = bAck_q;
    assign b_ok     = bOk_q;
    assign arena_0  = arena0_q;
    assign arena_1  = arena1_q;
    assign bombs_0  = bombs0_q;
    assign bombs_1  = bombs1_q;
    assign playerAx = ax_q;
    assign playerAy = ay_q;
    assign playerBx = bx_q;
    assign playerBy = by_q;
    assign hit_a    = hitA_q;
    assign hit_b    = hitB_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arena_arbiter.sv
// ---------------------------------------------------------------------------
// tb_arena_arbiter
// Directed bench for arena_arbiter. Stimulus pushes the expected ack
// (requester, ok, cycle) and hit events into queues; a monitor pops and
// compares whenever the DUT presents an ack or hit pulse.
// ---------------------------------------------------------------------------
module tb_arena_arbiter;

    localparam logic [2:0] UP = 3'd0, DOWN = 3'd1, LEFT = 3'd2, RIGHT = 3'd3, PLANT = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0;
    logic [2:0]  a_cmd = 3'd0, b_cmd = 3'd0;
    logic        a_ack, a_ok, b_ack, b_ok, hit_a, hit_b, busy;
    logic [99:0] arena_0, arena_1, bombs_0, bombs_1;
    logic [3:0]  playerAx, playerAy, playerBx, playerBy;

    typedef struct { bit isB; bit ok; int cycle; } ackExp_t;
    typedef struct { bit a; bit b; } hitExp_t;

    ackExp_t     ackQ[$];
    hitExp_t     hitQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busyCnt = 0;
    int          snap;
    logic [99:0] expArena0, expArena1;

    arena_arbiter dut (
        .clk(clk), .rst(rst), .tick(tick),
        .a_req(a_req), .a_cmd(a_cmd), .a_ack(a_ack), .a_ok(a_ok),
        .b_req(b_req), .b_cmd(b_cmd), .b_ack(b_ack), .b_ok(b_ok),
        .arena_0(arena_0), .arena_1(arena_1), .bombs_0(bombs_0), .bombs_1(bombs_1),
        .playerAx(playerAx), .playerAy(playerAy), .playerBx(playerBx), .playerBy(playerBy),
        .hit_a(hit_a), .hit_b(hit_b), .busy(busy)
    );

    // Free-running clock and a cycle counter used to time acks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] cellOf(input int i);
        return {arena_1[i], arena_0[i]};
    endfunction

    function automatic logic [1:0] bombOf(input int i);
        return {bombs_1[i], bombs_0[i]};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic scoreAck(input bit isB, input bit ok);
        ackExp_t e;
        if (ackQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack actual=%s required=none", isB ? "B" : "A");
        end else begin
            e = ackQ.pop_front();
            checkOutput("ack_requester", isB, e.isB);
            checkOutput("ack_ok", ok, e.ok);
            checkOutput("ack_cycle", cyc, e.cycle);
        end
    endtask

    task automatic scoreHit(input bit ha, input bit hb);
        hitExp_t e;
        if (hitQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_hit actual=%b%b required=none", ha, hb);
        end else begin
            e = hitQ.pop_front();
            checkOutput("hit_a", ha, e.a);
            checkOutput("hit_b", hb, e.b);
        end
    endtask

    // Monitor: samples on the falling edge, scores every ack and hit pulse
    // against the queued expectations and counts busy cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busyCnt++;
            if (a_ack) scoreAck(1'b0, a_ok);
            if (b_ack) scoreAck(1'b1, b_ok);
            if (hit_a || hit_b) scoreHit(hit_a, hit_b);
        end
    end

    // Issues an optional tick and optional A/B requests on one falling edge,
    // queues the expected acks (with latency in cycles) and holds each
    // request until its ack, bounded by a cycle budget.
    task automatic applyStimulus(input bit doTick,
                                 input bit doA, input logic [2:0] cmdA, input bit okA, input int latA,
                                 input bit doB, input logic [2:0] cmdB, input bit okB, input int latB);
        ackExp_t ea, eb;
        bit      pendA, pendB;
        int      base;
        base = cyc;
        ea = '{isB: 1'b0, ok: okA, cycle: base + latA};
        eb = '{isB: 1'b1, ok: okB, cycle: base + latB};
        if (doA && doB && latB < latA) begin
            ackQ.push_back(eb);
            ackQ.push_back(ea);
        end else begin
            if (doA) ackQ.push_back(ea);
            if (doB) ackQ.push_back(eb);
        end
        tick  = doTick;
        a_cmd = cmdA;
        a_req = doA;
        b_cmd = cmdB;
        b_req = doB;
        pendA = doA;
        pendB = doB;
        @(negedge clk);
        tick = 1'b0;
        for (int n = 0; n < 400 && (pendA || pendB); n++) begin
            if (pendA && a_ack) begin a_req = 1'b0; pendA = 1'b0; end
            if (pendB && b_ack) begin b_req = 1'b0; pendB = 1'b0; end
            if (pendA || pendB) @(negedge clk);
        end
        if (pendA || pendB) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout actual=pending A%0d B%0d required=acked", pendA, pendB);
            a_req = 1'b0;
            b_req = 1'b0;
        end
    endtask

    task automatic checkInitState(input string tag);
        checkOutput({tag, "_arena0"}, arena_0, expArena0);
        checkOutput({tag, "_arena1"}, arena_1, expArena1);
        checkOutput({tag, "_bombs0"}, bombs_0, 100'd0);
        checkOutput({tag, "_bombs1"}, bombs_1, 100'd0);
        checkOutput({tag, "_playerA"}, {playerAx, playerAy}, 8'h11);
        checkOutput({tag, "_playerB"}, {playerBx, playerBy}, 8'h88);
        checkOutput({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int blocks[14] = '{13, 17, 24, 32, 34, 38, 46, 51, 56, 57, 62, 63, 76, 84};
        expArena0 = '0;
        foreach (blocks[i]) expArena0[blocks[i]] = 1'b1;
        expArena0[88] = 1'b1;
        expArena1 = '0;
        expArena1[11] = 1'b1;
        expArena1[88] = 1'b1;

        @(negedge clk);
        rst = 1'b0;
        checkInitState("reset");
        checkOutput("reset_cell11", cellOf(11), 2'b10);
        checkOutput("reset_cell88", cellOf(88), 2'b11);
        checkOutput("reset_cell13", cellOf(13), 2'b01);
        checkOutput("reset_acks", {a_ack, a_ok, b_ack, b_ok, hit_a, hit_b}, 6'd0);

        // Legal move, then a move into a block.
        applyStimulus(0, 1, RIGHT, 1, 2, 0, UP, 0, 0);
        checkOutput("moveA_cell11", cellOf(11), 2'b00);
        checkOutput("moveA_cell12", cellOf(12), 2'b10);
        checkOutput("moveA_x", playerAx, 4'd2);
        applyStimulus(0, 1, RIGHT, 0, 2, 0, UP, 0, 0);
        checkOutput("blockedA_cell13", cellOf(13), 2'b01);
        checkOutput("blockedA_x", playerAx, 4'd2);

        // B to the right edge, then off-grid attempts with round-robin ties.
        applyStimulus(0, 0, UP, 0, 0, 1, RIGHT, 1, 2);
        checkOutput("moveB_cell89", cellOf(89), 2'b11);
        checkOutput("moveB_cell88", cellOf(88), 2'b00);
        checkOutput("moveB_x", playerBx, 4'd9);
        applyStimulus(0, 1, RIGHT, 0, 2, 1, RIGHT, 0, 4);
        checkOutput("edgeB_x", playerBx, 4'd9);
        applyStimulus(0, 1, RIGHT, 0, 2, 0, UP, 0, 0);
        applyStimulus(0, 1, RIGHT, 0, 4, 1, RIGHT, 0, 2);

        // Plant, second plant rejected, then three ticks to detonation.
        applyStimulus(0, 1, PLANT, 1, 2, 0, UP, 0, 0);
        checkOutput("plant_fuse", bombOf(12), 2'b11);
        applyStimulus(0, 1, PLANT, 0, 2, 0, UP, 0, 0);
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (120) @(negedge clk);
        checkOutput("tick1_fuse", bombOf(12), 2'b10);
        checkOutput("tick1_busy", busy, 1'b0);
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (120) @(negedge clk);
        checkOutput("tick2_fuse", bombOf(12), 2'b01);
        hitQ.push_back('{a: 1'b1, b: 1'b0});
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (120) @(negedge clk);
        checkOutput("boom_fuse", bombOf(12), 2'b00);
        checkOutput("boom_cell13", cellOf(13), 2'b00);
        checkOutput("boom_cell12", cellOf(12), 2'b10);
        checkOutput("boom_hits_seen", hitQ.size(), 0);

        // Tick and B request together: scan first, B served after it.
        applyStimulus(1, 0, UP, 0, 0, 1, LEFT, 1, 104);
        checkOutput("afterScanB_cell88", cellOf(88), 2'b11);
        checkOutput("afterScanB_x", playerBx, 4'd8);

        // Two ticks during a scan coalesce into one extra scan.
        snap = busyCnt;
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (19) @(negedge clk);
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (19) @(negedge clk);
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (300) @(negedge clk);
        checkOutput("coalesced_busy_cycles", busyCnt - snap, 202);

        // Reset at scan index 50 with a bomb live and a tick pending.
        applyStimulus(0, 1, PLANT, 1, 2, 0, UP, 0, 0);
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (9) @(negedge clk);
        applyStimulus(1, 0, UP, 0, 0, 0, UP, 0, 0);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkInitState("midreset");
        snap = busyCnt;
        repeat (20) @(negedge clk);
        checkOutput("midreset_no_pending", busyCnt - snap, 0);

        // Pointer back at A after reset.
        applyStimulus(0, 1, RIGHT, 1, 2, 1, UP, 1, 4);
        checkOutput("postreset_cell12", cellOf(12), 2'b10);
        checkOutput("postreset_cell78", cellOf(78), 2'b11);
        checkOutput("postreset_By", playerBy, 4'd7);

        repeat (5) @(negedge clk);
        checkOutput("ack_queue_empty", ackQ.size(), 0);
        checkOutput("hit_queue_empty", hitQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
